// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared types and defaults for the Montgomery datapath controllers
package mont_pkg;

    localparam int CNT_W_DEF   = 11;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_WAIT_SH,
        ST_SUB,
        ST_WAIT_SUB,
        ST_WB,
        ST_DONE
    } shift_mod_state_t;

endpackage

// File: rtl/watchdog_cnt.sv
// rtl/watchdog_cnt.sv - wait-state watchdog: counts enabled cycles, flags the last allowed one
// Ports:
//   clk, restn : clock, synchronous active-low reset
//   clear      : zero the count (asserted the cycle before a wait state is entered)
//   enable     : controller is in a wait state this cycle
//   expired    : this wait cycle is the TIMEOUT-th one; caller must give up now
module watchdog_cnt
    import mont_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic restn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    // Count is 0 on the first wait cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
    assign w_at_limit = (r_cnt >= CW'(TIMEOUT - 1));
    assign expired    = enable && w_at_limit;

    always_ff @(posedge clk) begin
        if (!restn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_mod_ctrl.sv
// rtl/shift_mod_ctrl.sv - sequencer for the k-step modular-doubling loop (x*2^k mod M)
// Ports:
//   clk, restn          : clock, synchronous active-low reset
//   start, k            : launch request and doubling count, taken only in IDLE
//   ready, busy         : idle / operating status
//   done, error         : end-of-operation pulse; error marks a watchdog abort
//   sr_enable, sr_shift : load and shift strobes to the shift register
//   sr_done             : shift-complete pulse from the shift register
//   sub_start           : start strobe to the wide subtractor
//   sub_done, sub_borrow: subtractor completion and borrow (1 = shifted < M)
//   sel_init, sel_sub   : feedback mux and result mux selects
//   iter_left           : doublings still to perform
module shift_mod_ctrl
    import mont_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             restn,
    input  logic             start,
    input  logic [CNT_W-1:0] k,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             sr_enable,
    output logic             sr_shift,
    input  logic             sr_done,
    output logic             sub_start,
    input  logic             sub_done,
    input  logic             sub_borrow,
    output logic             sel_init,
    output logic             sel_sub,
    output logic [CNT_W-1:0] iter_left
);

    shift_mod_state_t r_state;
    logic [CNT_W-1:0] r_iter_left;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_sr_enable;
    logic             r_sr_shift;
    logic             r_sub_start;
    logic             r_sel_init;
    logic             r_sel_sub;

    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;

    // SHIFT and SUB always lead straight into a wait state, so clearing
    // there gives a fresh count on the first wait cycle.
    assign w_wd_clear  = (r_state == ST_SHIFT) || (r_state == ST_SUB);
    assign w_wd_enable = (r_state == ST_WAIT_SH) || (r_state == ST_WAIT_SUB);

    watchdog_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .restn   (restn),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // Outputs are registered: each branch sets the values that belong to the
    // state being entered, so every strobe is high for exactly that one state.
    always_ff @(posedge clk) begin
        if (!restn) begin
            r_state     <= ST_IDLE;
            r_iter_left <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_sr_enable <= 1'b0;
            r_sr_shift  <= 1'b0;
            r_sub_start <= 1'b0;
            r_sel_init  <= 1'b1;
            r_sel_sub   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_sr_enable <= 1'b0;
            r_sr_shift  <= 1'b0;
            r_sub_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_iter_left <= k;
                        r_sel_init  <= 1'b1;
                        r_sel_sub   <= 1'b0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        if (k == '0) begin
                            // Nothing to double: operand passes through untouched.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_LOAD;
                            r_sr_enable <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    r_state    <= ST_SHIFT;
                    r_sr_shift <= 1'b1;
                end

                ST_SHIFT: begin
                    r_state <= ST_WAIT_SH;
                end

                ST_WAIT_SH: begin
                    if (sr_done) begin
                        r_state     <= ST_SUB;
                        r_sub_start <= 1'b1;
                    end else if (w_wd_expired) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end
                end

                ST_SUB: begin
                    r_state <= ST_WAIT_SUB;
                end

                ST_WAIT_SUB: begin
                    if (sub_done) begin
                        // No borrow means shifted >= M, so take the difference.
                        r_sel_sub <= ~sub_borrow;
                        r_state   <= ST_WB;
                    end else if (w_wd_expired) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end
                end

                ST_WB: begin
                    r_iter_left <= r_iter_left - CNT_W'(1);
                    r_sel_init  <= 1'b0;
                    if (r_iter_left == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_LOAD;
                        r_sr_enable <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign sr_enable = r_sr_enable;
    assign sr_shift  = r_sr_shift;
    assign sub_start = r_sub_start;
    assign sel_init  = r_sel_init;
    assign sel_sub   = r_sel_sub;
    assign iter_left = r_iter_left;

endmodule

// File: tb/tb_shift_mod_ctrl.sv
// tb/tb_shift_mod_ctrl.sv - directed self-checking bench for shift_mod_ctrl
module tb_shift_mod_ctrl;

    localparam int CNT_W = 11;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             restn = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] k = '0;
    logic             ready, busy, done, error;
    logic             sr_enable, sr_shift, sub_start;
    logic             sr_done, sub_done, sub_borrow;
    logic             sel_init, sel_sub;
    logic [CNT_W-1:0] iter_left;

    // datapath responder state
    logic       resp_sr_en = 1'b1;
    logic       resp_sub_en = 1'b1;
    logic       auto_sr_done = 1'b0;
    logic       auto_sub_done = 1'b0;
    logic       auto_borrow = 1'b0;
    logic       sr_pend = 1'b0;
    logic       sub_pend = 1'b0;
    logic       pend_b = 1'b0;
    int         b_idx = 0;
    logic [7:0] borrow_seq = '0;
    logic       man_sub_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // per-run observations
    int         t_done_cyc, t_err, n_en, n_sh, n_sub, overlap, busy_cyc;
    int         first_en, first_sh, first_sub;
    logic [7:0] selsub_log, selinit_log;
    int         inj_start_cyc = -1;
    int         inj_sub_cyc = -1;

    assign sr_done    = auto_sr_done;
    assign sub_done   = auto_sub_done | man_sub_done;
    assign sub_borrow = auto_borrow;

    always #5 clk = ~clk;

    shift_mod_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .restn      (restn),
        .start      (start),
        .k          (k),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .sr_enable  (sr_enable),
        .sr_shift   (sr_shift),
        .sr_done    (sr_done),
        .sub_start  (sub_start),
        .sub_done   (sub_done),
        .sub_borrow (sub_borrow),
        .sel_init   (sel_init),
        .sel_sub    (sel_sub),
        .iter_left  (iter_left)
    );

    // 1-cycle shift register and subtractor: answer in the cycle after the strobe
    always @(negedge clk) begin
        if (ready) b_idx = 0;
        auto_sr_done  = sr_pend & resp_sr_en;
        sr_pend       = sr_shift;
        auto_sub_done = sub_pend & resp_sub_en;
        auto_borrow   = sub_pend ? pend_b : 1'b0;
        sub_pend      = sub_start;
        if (sub_start) begin
            pend_b = borrow_seq[b_idx[2:0]];
            b_idx  = b_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flags"},
              {23'd0, ready, busy, done, error, sr_enable, sr_shift, sub_start, sel_init, sel_sub},
              32'b1_0_0_0_0_0_0_1_0);
        check({tag, "_iter"}, {21'd0, iter_left}, 32'd0);
    endtask

    // Launch one operation (start sampled in cycle 0), observe cycles 1..max_cyc
    task automatic run_op(input logic [CNT_W-1:0] kv, input int max_cyc);
        int cnt;
        t_done_cyc = -1; t_err = 0; n_en = 0; n_sh = 0; n_sub = 0;
        overlap = 0; busy_cyc = 0; first_en = -1; first_sh = -1; first_sub = -1;
        selsub_log = '0; selinit_log = '0;
        @(negedge clk);
        start = 1'b1;
        k     = kv;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            cnt = int'(sr_enable) + int'(sr_shift) + int'(sub_start);
            if (cnt > 1) overlap++;
            if (busy) busy_cyc++;
            if (sr_enable) begin
                if (first_en < 0) first_en = n;
                if (n_en < 8) selinit_log[n_en] = sel_init;
                n_en++;
            end
            if (sr_shift) begin
                if (first_sh < 0) first_sh = n;
                n_sh++;
            end
            if (sub_start) begin
                if (first_sub < 0) first_sub = n;
                n_sub++;
            end
            if (n % 6 == 0 && n / 6 <= 8) selsub_log[n/6-1] = sel_sub;
            if (done) begin
                t_done_cyc = n;
                t_err      = int'(error);
                break;
            end
            start        = (n == inj_start_cyc);
            k            = (n == inj_start_cyc) ? CNT_W'(7) : kv;
            man_sub_done = (n == inj_sub_cyc);
        end
        start        = 1'b0;
        man_sub_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // reset
        restn = 1'b0;
        idle(3);
        check_reset_vals("reset");
        restn = 1'b1;
        idle(2);

        // k=1, borrow=1
        borrow_seq = 8'b0000_0001;
        run_op(CNT_W'(1), 40);
        check("k1_done_cyc", t_done_cyc, 7);
        check("k1_strobe_counts", {n_en[7:0], n_sh[7:0], n_sub[7:0]}, {8'd1, 8'd1, 8'd1});
        check("k1_strobe_order", {first_en[7:0], first_sh[7:0], first_sub[7:0]}, {8'd1, 8'd2, 8'd4});
        check("k1_no_overlap", overlap, 0);
        check("k1_sel_sub", {31'd0, sel_sub}, 32'd0);
        check("k1_iter_left", {21'd0, iter_left}, 32'd0);
        check("k1_error", t_err, 0);
        check("k1_busy_cycles", busy_cyc, 7);
        @(negedge clk);
        check("k1_ready_after", {30'd0, ready, busy}, 32'b10);
        idle(2);

        // k=3, borrows 0,1,0
        borrow_seq = 8'b0000_0010;
        run_op(CNT_W'(3), 60);
        check("k3_done_cyc", t_done_cyc, 19);
        check("k3_sel_sub_log", {24'd0, selsub_log}, 32'b101);
        check("k3_sel_init_log", {24'd0, selinit_log}, 32'b001);
        check("k3_loads", n_en, 3);
        check("k3_no_overlap", overlap, 0);
        check("k3_final_sel_sub", {31'd0, sel_sub}, 32'd1);
        idle(2);

        // k=0
        run_op(CNT_W'(0), 10);
        check("k0_done_cyc", t_done_cyc, 1);
        check("k0_no_strobes", n_en + n_sh + n_sub, 0);
        check("k0_busy_cycles", busy_cyc, 1);
        check("k0_error", t_err, 0);
        @(negedge clk);
        check("k0_ready_after", {30'd0, ready, busy}, 32'b10);
        idle(2);

        // watchdog: sr_done withheld, WAIT_SH entered at cycle 3
        resp_sr_en = 1'b0;
        run_op(CNT_W'(2), 60);
        check("tmo_done_cyc", t_done_cyc, 3 + TMO);
        check("tmo_error", t_err, 1);
        check("tmo_iter_frozen", {21'd0, iter_left}, 32'd2);
        check("tmo_no_sub", n_sub, 0);
        @(negedge clk);
        check("tmo_idle_after", {29'd0, ready, busy, error}, 32'b100);
        resp_sr_en = 1'b1;
        idle(2);

        // reset during WAIT_SUB with k=5
        resp_sub_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k     = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        idle(3);
        check("rst_sub_start_c4", {31'd0, sub_start}, 32'd1);
        @(negedge clk);
        check("rst_in_wait_sub", {30'd0, busy, sub_start}, 32'b10);
        restn = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        restn        = 1'b1;
        man_sub_done = 1'b1;
        @(negedge clk);
        man_sub_done = 1'b0;
        check("rst_late_sub_ignored",
              {28'd0, ready, busy, sel_sub, sub_start}, 32'b1000);
        resp_sub_en = 1'b1;
        idle(1);
        borrow_seq = 8'b0000_0000;
        run_op(CNT_W'(1), 40);
        check("rst_rerun_done_cyc", t_done_cyc, 7);
        check("rst_rerun_sel_sub", {31'd0, sel_sub}, 32'd1);
        idle(2);

        // restart and spurious sub_done during a k=2 run
        borrow_seq    = 8'b0000_0011;
        inj_start_cyc = 4;
        inj_sub_cyc   = 3;
        run_op(CNT_W'(2), 60);
        inj_start_cyc = -1;
        inj_sub_cyc   = -1;
        check("inj_done_cyc", t_done_cyc, 13);
        check("inj_loads", n_en, 2);
        check("inj_iter_left", {21'd0, iter_left}, 32'd0);
        check("inj_error", t_err, 0);
        check("inj_sel_sub_log", {24'd0, selsub_log}, 32'b00);
        idle(3);
        check("inj_stays_idle", {29'd0, ready, busy, sr_enable}, 32'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_mod_ctrl.md
# shift_mod_ctrl

Sequencer for the modular-doubling loop of the Montgomery datapath. It drives the 1024-bit shift register (load/shift strobes, done pulse back) and the wide subtractor that computes `shifted - M`. From the subtractor's borrow it selects which value feeds the next iteration, and repeats for `k` doublings. The result is `x·2^k mod M`, used for Montgomery domain conversion and R² precompute. It sits between the top-level operation FSM and the datapath, and owns no wide data itself.

## Interface
- `CNT_W`, 11: width of iteration count (max k = 2^CNT_W − 1).
- `TIMEOUT`, 64: cycles allowed in any wait state before error.
- `clk`  in  1  clock, all logic on rising edge.
- `restn`  in  1  synchronous, active-low reset.
- `start`  in  1  begin operation, sampled only in IDLE.
- `k`  in  CNT_W  number of doublings, captured with `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of operation (also on error).
- `error`  out  1  one-cycle pulse coincident with `done` on timeout.
- `sr_enable`  out  1  load strobe to shift register.
- `sr_shift`  out  1  shift strobe to shift register.
- `sr_done`  in  1  shift-complete pulse from shift register.
- `sub_start`  out  1  start strobe to subtractor.
- `sub_done`  in  1  subtractor-complete pulse.
- `sub_borrow`  in  1  valid with `sub_done`; 1 = `shifted < M`.
- `sel_init`  out  1  feedback mux: 1 = external operand, 0 = previous result.
- `sel_sub`  out  1  result mux: 1 = subtractor output, 0 = shifted value.
- `iter_left`  out  CNT_W  remaining doublings.

## Operation
- States: IDLE, LOAD, SHIFT, WAIT_SH, SUB, WAIT_SUB, WB, DONE.
- IDLE + `start`, k≠0: capture k into `iter_left`, set `sel_init`=1, go to LOAD.
- IDLE + `start`, k=0: go straight to DONE. No datapath strobes are issued; the consumer uses the operand unchanged.
- LOAD: `sr_enable`=1, go to SHIFT.
- SHIFT: `sr_shift`=1, go to WAIT_SH.
- WAIT_SH: on `sr_done`, go to SUB.
- SUB: `sub_start`=1, go to WAIT_SUB.
- WAIT_SUB: on `sub_done`, register `sel_sub` = ~`sub_borrow`, go to WB.
- WB: `iter_left` −1 and `sel_init`=0. If the new `iter_left`=0, go to DONE; else go to LOAD.
- DONE: `done`=1 for one cycle, go to IDLE. `sel_sub` holds the last decision until the next `start`.
- Strobes are Moore outputs, exactly one cycle each, never overlapping.
- Watchdog: a counter clears on entry to WAIT_SH/WAIT_SUB and increments each cycle there. On reaching TIMEOUT, go to DONE with `error`=1. `iter_left` freezes at its current value.
- `start` while busy is ignored. `sr_done`/`sub_done` outside their wait states are ignored.
- `sr_done` and `sub_done` arriving in the same cycle: only the one matching the current state acts.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `error`=0, all strobes 0, `sel_init`=1, `sel_sub`=0, `iter_left`=0, state IDLE.
- Reset mid-operation: next cycle is IDLE with the reset values above; no pending strobe is emitted.
- With a 1-cycle shift register (`sr_done` the cycle after `sr_shift`) and `sub_done` the cycle after `sub_start`, one iteration takes 6 cycles (LOAD…WB).
- Total latency from the `start` cycle to the `done` cycle is 6k+1 cycles; for k=0 it is 1 cycle.
- `sel_init` and `sel_sub` are stable from WB through the following LOAD, so the mux output is valid when `sr_enable` fires.

## Structure
- Shared package `mont_pkg`: state enum `shift_mod_state_t`, `CNT_W` default, `TIMEOUT` default.
- Sub-module `watchdog_cnt` (clear, enable, `expired` output), parameterized by TIMEOUT; reusable by other controllers.
- FSM plus iteration counter stay in `shift_mod_ctrl`.

## Test plan
- k=1, `sub_borrow`=1: `sr_enable`, `sr_shift`, `sub_start` each pulse once in order; `sel_sub`=0; `done` 7 cycles after `start`; `iter_left`=0.
- k=3, borrow sequence 0,1,0: `sel_sub` goes 1,0,1 at successive WBs; `sel_init`=1 only for the first LOAD; `done` at cycle 19.
- k=0: `done` the cycle after `start`; no strobe ever asserted; `busy` high for 1 cycle.
- TIMEOUT=16, `sr_done` withheld: `done`=`error`=1 exactly 16 cycles after entering WAIT_SH; then IDLE with `ready`=1.
- `restn` low during WAIT_SUB with k=5: all outputs at reset values next cycle. A late `sub_done` is ignored and a new `start` runs cleanly.
- `start` pulsed again mid-operation with k=7, plus a spurious `sub_done` in WAIT_SH: neither has any effect; the original k=2 run completes in 13 cycles.
